muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_decode.sv | 37 +++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V M-extension encodings, FSM state type and op descriptor for the mul/div unit.
package riscv_pkg;

  localparam logic [6:0] OP_R          = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Operation latched at accept; neg selects the final two's-complement fix-up
  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic high_half;
    logic neg;
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline (master) and the mul/div unit (slave).
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [6:0]                     opcode;
  logic [2:0]                     funct3;
  logic [6:0]                     funct7;
  logic [XLEN-1:0]                rs1;
  logic [XLEN-1:0]                rs2;
  logic [riscv_pkg::TAG_W-1:0]    in_tag;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [XLEN-1:0]                out_result;
  logic [riscv_pkg::TAG_W-1:0]    out_tag;
  logic                           busy;

  modport master (
    output in_valid, opcode, funct3, funct7, rs1, rs2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rs1, rs2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/muldiv_decode.sv
// Combinational decode of an R-type M-extension instruction into datapath controls.
module muldiv_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       is_m_o,
  output logic       is_div_o,
  output logic       is_rem_o,
  output logic       high_half_o,
  output logic       rs1_signed_o,
  output logic       rs2_signed_o
);

  always_comb begin
    is_m_o       = (opcode_i == OP_R) && (funct7_i == FUNCT7_MULDIV);
    is_div_o     = 1'b0;
    is_rem_o     = 1'b0;
    high_half_o  = 1'b0;
    rs1_signed_o = 1'b0;
    rs2_signed_o = 1'b0;
    // MUL keeps the low half, which is sign-agnostic, so it runs unsigned
    case (funct3_i)
      F3_MUL:    ;
      F3_MULH:   begin high_half_o = 1'b1; rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; end
      F3_MULHSU: begin high_half_o = 1'b1; rs1_signed_o = 1'b1; end
      F3_MULHU:  high_half_o = 1'b1;
      F3_DIV:    begin is_div_o = 1'b1; rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; end
      F3_DIVU:   is_div_o = 1'b1;
      F3_REM:    begin is_div_o = 1'b1; is_rem_o = 1'b1; rs1_signed_o = 1'b1; rs2_signed_o = 1'b1; end
      F3_REMU:   begin is_div_o = 1'b1; is_rem_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with optional single-cycle multiply.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic is_m, is_div, is_rem, high_half, rs1_signed, rs2_signed;

  muldiv_decode u_decode (
    .opcode_i     (bus.opcode),
    .funct3_i     (bus.funct3),
    .funct7_i     (bus.funct7),
    .is_m_o       (is_m),
    .is_div_o     (is_div),
    .is_rem_o     (is_rem),
    .high_half_o  (high_half),
    .rs1_signed_o (rs1_signed),
    .rs2_signed_o (rs2_signed)
  );

  muldiv_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W2-1:0]         acc_q, acc_d;
  logic [XLEN-1:0]       opb_q, opb_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  muldiv_op_t            op_q, op_d;

  logic                  a_neg, b_neg, div_zero, div_ovf, accept;
  logic [XLEN-1:0]       a_mag, b_mag, fast_res;
  logic [W2-1:0]         a_ext, b_ext, prod_fast;

  // Request-side operand conditioning and special-case detection
  always_comb begin
    a_neg     = rs1_signed & bus.rs1[XLEN-1];
    b_neg     = rs2_signed & bus.rs2[XLEN-1];
    a_mag     = a_neg ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
    b_mag     = b_neg ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
    div_zero  = (bus.rs2 == '0);
    div_ovf   = rs1_signed & (bus.rs1 == XMIN) & (bus.rs2 == '1);
    a_ext     = rs1_signed ? {{XLEN{bus.rs1[XLEN-1]}}, bus.rs1} : {{XLEN{1'b0}}, bus.rs1};
    b_ext     = rs2_signed ? {{XLEN{bus.rs2[XLEN-1]}}, bus.rs2} : {{XLEN{1'b0}}, bus.rs2};
    prod_fast = a_ext * b_ext;
    fast_res  = high_half ? prod_fast[W2-1:XLEN] : prod_fast[XLEN-1:0];
    accept    = bus.in_valid & (state_q == IDLE) & ~bus.flush & is_m;
  end

  logic [XLEN:0]   mul_sum, rem_sh;
  logic [XLEN-1:0] rem_diff, quo_fin, rem_fin, fin_res;
  logic            q_bit;
  logic [W2-1:0]   acc_n, prod_fin;

  // One iteration step; acc holds {partial product | multiplier} or {remainder | quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    q_bit    = (rem_sh >= {1'b0, opb_q});
    rem_diff = XLEN'(rem_sh - {1'b0, opb_q});
    if (op_q.is_div) begin
      acc_n = {(q_bit ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
    end else begin
      acc_n = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fin = op_q.neg ? (~acc_n + W2'(1)) : acc_n;
    quo_fin  = op_q.neg ? (~acc_n[XLEN-1:0] + XLEN'(1)) : acc_n[XLEN-1:0];
    rem_fin  = op_q.neg ? (~acc_n[W2-1:XLEN] + XLEN'(1)) : acc_n[W2-1:XLEN];
    if (op_q.is_div) begin
      fin_res = op_q.is_rem ? rem_fin : quo_fin;
    end else begin
      fin_res = op_q.high_half ? prod_fin[W2-1:XLEN] : prod_fin[XLEN-1:0];
    end
  end

  // Next-state: flush wins over any handshake; the final iteration lands directly in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    res_d   = res_q;
    tag_d   = tag_q;
    op_d    = op_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tag_d = bus.in_tag;
            cnt_d = '0;
            op_d  = '{is_div: is_div, is_rem: is_rem, high_half: high_half,
                      neg: (is_rem ? a_neg : (a_neg ^ b_neg))};
            acc_d = {{XLEN{1'b0}}, a_mag};
            opb_d = b_mag;
            if (is_div && div_zero) begin
              res_d   = is_rem ? bus.rs1 : '1;
              state_d = DONE;
            end else if (is_div && div_ovf) begin
              res_d   = is_rem ? '0 : XMIN;
              state_d = DONE;
            end else if (!is_div && FAST_MUL) begin
              res_d   = fast_res;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = acc_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            res_d   = fin_res;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: an iterative and a fast-multiply instance driven in lock-step.
module tb_muldiv_unit;
  import riscv_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int          LAT_ITER = XLEN + 1;
  localparam logic [31:0] MIN      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  in_tag;
  logic        ordy [2];
  logic        ov [2], irdy [2], bsy [2];
  logic [31:0] ores [2];
  logic [4:0]  otag [2];

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus0 ();
  muldiv_unit_if #(.XLEN(XLEN)) bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.opcode   = opcode;    assign bus1.opcode   = opcode;
  assign bus0.funct3   = funct3;    assign bus1.funct3   = funct3;
  assign bus0.funct7   = funct7;    assign bus1.funct7   = funct7;
  assign bus0.rs1      = rs1;       assign bus1.rs1      = rs1;
  assign bus0.rs2      = rs2;       assign bus1.rs2      = rs2;
  assign bus0.in_tag   = in_tag;    assign bus1.in_tag   = in_tag;
  assign bus0.flush    = flush;     assign bus1.flush    = flush;
  assign bus0.out_ready = ordy[0];  assign bus1.out_ready = ordy[1];
  assign ov[0]   = bus0.out_valid;  assign ov[1]   = bus1.out_valid;
  assign irdy[0] = bus0.in_ready;   assign irdy[1] = bus1.in_ready;
  assign bsy[0]  = bus0.busy;       assign bsy[1]  = bus1.busy;
  assign ores[0] = bus0.out_result; assign ores[1] = bus1.out_result;
  assign otag[0] = bus0.out_tag;    assign otag[1] = bus1.out_tag;

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut_iter (.clk(clk), .rst_n(rst_n), .bus(bus0));
  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut_fast (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  exp_t sb0_q [$];
  exp_t sb1_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [2:0]  f3r;
  logic [31:0] ra, rb;
  logic [4:0]  tg;
  logic        seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sbu = ub;
    r = '0;
    case (f3)
      F3_MUL:    begin up = ua * ub;  r = up[31:0];  end
      F3_MULH:   begin sp = sa * sb;  r = sp[63:32]; end
      F3_MULHSU: begin sp = sa * sbu; r = sp[63:32]; end
      F3_MULHU:  begin up = ua * ub;  r = up[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = MIN;
        else begin sp = sa / sb; r = sp[31:0]; end
      end
      F3_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) r = a;
        else if (a == MIN && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin sp = sa % sb; r = sp[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input bit fast, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f3[2]) return fast ? 1 : LAT_ITER;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return LAT_ITER;
  endfunction

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [6:0] op7, input logic [6:0] f7);
    @(negedge clk);
    opcode = op7; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    exp_t e;
    e.res = ref_model(f3, a, b);
    e.tag = tag;
    e.lat = exp_lat(1'b0, f3, a, b);
    sb0_q.push_back(e);
    e.lat = exp_lat(1'b1, f3, a, b);
    sb1_q.push_back(e);
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    e.res = '0; e.tag = '0; e.lat = 0; ok = 1'b0;
    if (k == 0) begin
      if (sb0_q.size() > 0) begin e = sb0_q.pop_front(); ok = 1'b1; end
    end else begin
      if (sb1_q.size() > 0) begin e = sb1_q.pop_front(); ok = 1'b1; end
    end
  endtask

  // Pop and compare each instance's result when it appears; hold>0 stalls the consumer
  task automatic wait_results(input string name, input int hold);
    bit   done [2];
    exp_t e [2];
    bit   ok;
    int   cyc;
    done[0] = 1'b0; done[1] = 1'b0; cyc = 0;
    while (!(done[0] && done[1]) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && ov[k]) begin
          done[k] = 1'b1;
          pop_exp(k, e[k], ok);
          chk($sformatf("%s d%0d scoreboard", name, k), 32'(ok), 32'd1);
          chk($sformatf("%s d%0d result", name, k), ores[k], e[k].res);
          chk($sformatf("%s d%0d tag", name, k), 32'(otag[k]), 32'(e[k].tag));
          chk($sformatf("%s d%0d latency", name, k), 32'(cyc), 32'(e[k].lat));
        end
      end
    end
    for (int k = 0; k < 2; k++) chk($sformatf("%s d%0d timeout", name, k), 32'(done[k]), 32'd1);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("%s d%0d stall result", name, k), ores[k], e[k].res);
          chk($sformatf("%s d%0d stall tag", name, k), 32'(otag[k]), 32'(e[k].tag));
          chk($sformatf("%s d%0d stall valid", name, k), 32'(ov[k]), 32'd1);
          chk($sformatf("%s d%0d stall busy", name, k), 32'(bsy[k]), 32'd1);
          chk($sformatf("%s d%0d stall in_ready", name, k), 32'(irdy[k]), 32'd0);
        end
      end
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("%s d%0d released", name, k), 32'(ov[k]), 32'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    logic [4:0] tag;
    tag = 5'($urandom_range(1, 31));
    push_exp(f3, a, b, tag);
    drive_req(f3, a, b, tag, OP_R, FUNCT7_MULDIV);
    wait_results(name, 0);
  endtask

  task automatic chk_idle(input string name);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d in_ready", name, k), 32'(irdy[k]), 32'd1);
      chk($sformatf("%s d%0d busy", name, k), 32'(bsy[k]), 32'd0);
      chk($sformatf("%s d%0d out_valid", name, k), 32'(ov[k]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    opcode = '0; funct7 = '0; funct3 = '0; rs1 = '0; rs2 = '0; in_tag = '0;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset d%0d result", k), ores[k], 32'd0);
      chk($sformatf("reset d%0d tag", k), 32'(otag[k]), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("remu_5_0", F3_REMU, 32'd5, 32'd0);
    run_op("divu_5_0", F3_DIVU, 32'd5, 32'd0);
    run_op("rem_m7_0", F3_REM, 32'hFFFF_FFF9, 32'd0);
    run_op("div_ovf", F3_DIV, MIN, 32'hFFFF_FFFF);
    run_op("rem_ovf", F3_REM, MIN, 32'hFFFF_FFFF);
    run_op("divu_min_m1", F3_DIVU, MIN, 32'hFFFF_FFFF);
    run_op("mulh_m1_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_m1_max", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_neg", F3_MUL, 32'hFFFF_FFFD, 32'd7);
    run_op("div_min_2", F3_DIV, MIN, 32'd2);

    for (int i = 0; i < 16; i++) begin
      f3r = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i % 3 == 1) rb = ~rb;
      run_op($sformatf("rand%0d_f%0d", i, f3r), f3r, ra, rb);
    end

    // Non-M encodings must be ignored
    drive_req(F3_MUL, 32'd3, 32'd4, 5'd7, OP_R, 7'b0000000);
    @(negedge clk);
    chk_idle("ignore_funct7");
    drive_req(F3_DIV, 32'd9, 32'd3, 5'd7, 7'b0010011, FUNCT7_MULDIV);
    @(negedge clk);
    chk_idle("ignore_opcode");

    // Flush on the tenth cycle of a divide
    drive_req(F3_DIV, 32'd1000, 32'd7, 5'd9, OP_R, FUNCT7_MULDIV);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("pre_flush d%0d busy", k), 32'(bsy[k]), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk_idle("flush_calc");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0] || ov[1]) seen = 1'b1;
    end
    chk("flush_calc no result", 32'(seen), 32'd0);
    run_op("mul_3_4", F3_MUL, 32'd3, 32'd4);

    // Flush beats a same-cycle accept
    @(negedge clk);
    opcode = OP_R; funct7 = FUNCT7_MULDIV; funct3 = F3_DIVU; rs1 = 32'd5; rs2 = 32'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk_idle("flush_accept");

    // Flush drops a result waiting in DONE
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    drive_req(F3_DIVU, 32'd5, 32'd0, 5'd3, OP_R, FUNCT7_MULDIV);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("pre_flush_done d%0d valid", k), 32'(ov[k]), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk_idle("flush_done");
    ordy[0] = 1'b1; ordy[1] = 1'b1;

    // Consumer stall for five cycles in DONE
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    tg = 5'd21;
    push_exp(F3_DIV, 32'd1000, 32'd7, tg);
    drive_req(F3_DIV, 32'd1000, 32'd7, tg, OP_R, FUNCT7_MULDIV);
    wait_results("backpressure", 5);

    // Asynchronous reset in the middle of an iteration
    drive_req(F3_DIVU, 32'd12345, 32'd3, 5'd17, OP_R, FUNCT7_MULDIV);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("reset_mid");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_mid d%0d result", k), ores[k], 32'd0);
      chk($sformatf("reset_mid d%0d tag", k), 32'(otag[k]), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("first_after_reset", F3_REMU, 32'd100, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
